char_out_uart: RTL and testbench

CHAR_OUT_UART -- requirements
Module: char_out_uart

---
 rtl/char_out_uart.sv | 78 +++++++
 tb/tb_char_out_uart.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/char_out_uart.sv
// char_out_uart: buffers core characters in a FIFO and sends them as 8N1 UART frames.
module char_out_uart #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     phi,
  input  logic                     rst,
  input  logic [7:0]               char_out,
  input  logic                     char_out_val,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          bitEnd, pop, push, full;
  assign bitEnd = timer == TW'(CLKS_PER_BIT - 1);
  assign full   = fifo_count == (AW + 1)'(DEPTH);
  // a pop at the end of STOP chains the next frame with no idle gap
  assign pop    = (fifo_count != 0) && (state == IDLE || (state == STOP && bitEnd));
  assign push   = char_out_val && (!full || pop);
  assign busy   = (state != IDLE) || (fifo_count != 0);
  always_ff @(posedge phi)
    if (push) mem[wrPtr] <= char_out;
  always_ff @(posedge phi or posedge rst)
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wrPtr      <= push ? wrPtr + 1'b1 : wrPtr;
      rdPtr      <= pop ? rdPtr + 1'b1 : rdPtr;
      fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow   <= overflow | (char_out_val & ~push);
    end
  always_ff @(posedge phi or posedge rst)
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
    end else begin
      // tx is registered from the current state, so the line trails the FSM by one cycle
      tx <= state == START ? 1'b0 : state == DATA ? shiftReg[0] : 1'b1;
      if (pop) begin
        shiftReg <= mem[rdPtr];
        state    <= START;
        timer    <= '0;
        bitCnt   <= '0;
      end else if (state != IDLE) begin
        timer <= bitEnd ? '0 : timer + 1'b1;
        if (bitEnd) begin
          case (state)
            START: state <= DATA;
            DATA: begin
              shiftReg <= shiftReg >> 1;
              bitCnt   <= bitCnt + 1'b1;
              state    <= bitCnt == 3'd7 ? STOP : DATA;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
endmodule

// File: tb/tb_char_out_uart.sv
// tb_char_out_uart: random and directed stimulus checked against a frame-level model.
module tb_char_out_uart;
  localparam int C = 4;
  localparam int D = 16;
  logic       phi = 1'b0;
  logic       rst;
  logic [7:0] char_out;
  logic       char_out_val;
  logic       tx, busy, overflow;
  logic [4:0] fifo_count;
  int total = 0;
  int bad = 0;

  char_out_uart #(.DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .phi(phi), .rst(rst), .char_out(char_out), .char_out_val(char_out_val),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 phi = ~phi;

  // model: t is the position (in cycles) inside the current frame, -1 when idle
  int         t = -1;
  logic [7:0] q[$];
  logic [7:0] cur;
  logic       mOvf = 1'b0;
  logic       mTx = 1'b1;
  always @(posedge phi or posedge rst) begin
    if (rst) begin
      t = -1; q.delete(); mOvf = 1'b0; mTx = 1'b1;
    end else begin
      logic lvl;
      int   tn;
      lvl = (t < 0) ? 1'b1 : (t < C) ? 1'b0 : (t < 9*C) ? cur[(t - C) / C] : 1'b1;
      if (q.size() > 0 && (t < 0 || t == 10*C - 1)) begin
        cur = q.pop_front();
        tn = 0;
      end else
        tn = (t < 0 || t == 10*C - 1) ? -1 : t + 1;
      if (char_out_val) begin
        if (q.size() < D) q.push_back(char_out);
        else mOvf = 1'b1;
      end
      t = tn;
      mTx = lvl;
    end
  end

  always @(negedge phi)
    if (!rst) begin
      logic [7:0] exp;
      exp = {mTx, (t >= 0 || q.size() != 0), mOvf, 5'(q.size())};
      total++;
      if ({tx, busy, overflow, fifo_count} !== exp) begin
        bad++;
        $display("FAIL cycle t=%0t {tx,busy,ovf,count} got=%b want=%b", $time,
                 {tx, busy, overflow, fifo_count}, exp);
      end
    end

  // independent line receiver sampling mid-bit
  int         rxCnt = -1;
  logic [7:0] rxByte;
  logic [7:0] rxq[$];
  int         maxCnt = 0;
  always @(negedge phi) begin
    if (rst) rxCnt = -1;
    else if (rxCnt < 0) begin
      if (tx == 1'b0) rxCnt = 0;
    end else begin
      rxCnt++;
      if (rxCnt % C == C/2 && rxCnt < 9*C) rxByte[rxCnt/C - 1] = tx;
      if (rxCnt == 9*C + C/2) begin
        rxq.push_back(rxByte);
        rxCnt = -1;
      end
    end
    if (int'(fifo_count) > maxCnt) maxCnt = int'(fifo_count);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    char_out = c;
    char_out_val = 1'b1;
    @(negedge phi);
    char_out_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge phi);
  endtask

  logic       txs[43];
  logic       bsy[43];
  logic [7:0] sent[$];

  initial begin
    rst = 1'b1; char_out_val = 1'b0; char_out = 8'h00;
    #3;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(2);
    // single 0x41 frame, sample k taken after the k-th edge following the strobe edge
    send(8'h41);
    for (int k = 0; k < 43; k++) begin
      txs[k] = tx; bsy[k] = busy;
      @(negedge phi);
    end
    chk("a_tx_s1", 32'(txs[1]), 32'd1);
    chk("a_tx_start", 32'(txs[2]), 32'd0);
    chk("a_tx_start_end", 32'(txs[5]), 32'd0);
    chk("a_tx_b0", 32'(txs[6]), 32'd1);
    chk("a_tx_b1", 32'(txs[10]), 32'd0);
    chk("a_tx_b6", 32'(txs[30]), 32'd1);
    chk("a_tx_b7", 32'(txs[34]), 32'd0);
    chk("a_tx_stop", 32'(txs[41]), 32'd1);
    chk("a_busy_mid", 32'(bsy[40]), 32'd1);
    chk("a_busy_end", 32'(bsy[41]), 32'd0);
    // three back-to-back frames
    send(8'h00); send(8'hFF); send(8'h55);
    idle(130);
    chk("b_ovf", 32'(overflow), 32'd0);
    // 18 strobes: one in flight, 16 buffered, last dropped
    for (int i = 0; i < 18; i++) send(8'($urandom));
    chk("c_count", 32'(fifo_count), 32'd16);
    chk("c_ovf", 32'(overflow), 32'd1);
    idle(17*40 + 10);
    chk("c_ovf_held", 32'(overflow), 32'd1);
    chk("c_busy", 32'(busy), 32'd0);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("c_ovf_clr", 32'(overflow), 32'd0);
    // full FIFO with a push on the STOP-end pop edge
    for (int i = 0; i < 17; i++) send(8'($urandom));
    idle(24);
    send(8'hC3);
    chk("d_count", 32'(fifo_count), 32'd16);
    chk("d_ovf", 32'(overflow), 32'd0);
    idle(17*40 + 10);
    chk("d_busy", 32'(busy), 32'd0);
    // asynchronous reset during data bit 3, strobe ignored while held
    send(8'h33);
    idle(20);
    #1 rst = 1'b1; char_out_val = 1'b1; char_out = 8'hEE;
    #1;
    chk("e_tx", 32'(tx), 32'd1);
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_count", 32'(fifo_count), 32'd0);
    idle(2);
    char_out_val = 1'b0; rst = 1'b0;
    idle(1);
    chk("e_ignored", 32'(fifo_count), 32'd0);
    rxq.delete();
    send(8'h5A);
    idle(45);
    chk("e_rx_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("e_rx_val", 32'(rxq[0]), 32'h5A);
    // pointer wrap with sparse traffic
    rxq.delete();
    maxCnt = 0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      sent.push_back(c);
      send(c);
      idle(43);
    end
    idle(50);
    chk("f_rx_n", 32'(rxq.size()), 32'd40);
    for (int i = 0; i < 40 && i < rxq.size(); i++) chk("f_rx_val", 32'(rxq[i]), 32'(sent[i]));
    chk("f_maxcount", 32'(maxCnt <= 1), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
